// File: rtl/ltssm.sv
// ltssm: simplified 4-lane PCIe LTSSM for simulation-level link bring-up.
// Two instances are cross-wired back to back (req->ack, ts_o->ts_i). Each
// instance detects receivers, trains with TS1/TS2 ordered sets and raises
// linkup in L0.
//
// Optional feature macro: LTSSM_FAST_SIM_EN -- when defined, the dwell,
// timeout and TS1 minimum are forced to 64 / 4096 / 16 cycles.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   laneN_rx_det              receiver termination present on lane N
//   laneN_idel_break          electrical idle exit seen on lane N
//   laneN_rx_det_seq_req      local detect request (to partner ack)
//   laneN_rx_det_seq_ack      partner detect request
//   laneN_ts_i / _vld         received ordered set and its valid
//   laneN_ts_o / _vld         transmitted ordered set and its valid
//   linkup                    link in L0
module ltssm #(
    parameter int unsigned QUIET_CYCLES   = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 24000,
    parameter int unsigned TS1_TX_MIN     = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lane0_rx_det,
    input  logic         lane0_idel_break,
    output logic         lane0_rx_det_seq_req,
    input  logic         lane0_rx_det_seq_ack,
    input  logic [127:0] lane0_ts_i,
    input  logic         lane0_ts_i_vld,
    output logic [127:0] lane0_ts_o,
    output logic         lane0_ts_o_vld,
    input  logic         lane1_rx_det,
    input  logic         lane1_idel_break,
    output logic         lane1_rx_det_seq_req,
    input  logic         lane1_rx_det_seq_ack,
    input  logic [127:0] lane1_ts_i,
    input  logic         lane1_ts_i_vld,
    output logic [127:0] lane1_ts_o,
    output logic         lane1_ts_o_vld,
    input  logic         lane2_rx_det,
    input  logic         lane2_idel_break,
    output logic         lane2_rx_det_seq_req,
    input  logic         lane2_rx_det_seq_ack,
    input  logic [127:0] lane2_ts_i,
    input  logic         lane2_ts_i_vld,
    output logic [127:0] lane2_ts_o,
    output logic         lane2_ts_o_vld,
    input  logic         lane3_rx_det,
    input  logic         lane3_idel_break,
    output logic         lane3_rx_det_seq_req,
    input  logic         lane3_rx_det_seq_ack,
    input  logic [127:0] lane3_ts_i,
    input  logic         lane3_ts_i_vld,
    output logic [127:0] lane3_ts_o,
    output logic         lane3_ts_o_vld,
    output logic         linkup
);

`ifdef LTSSM_FAST_SIM_EN
    localparam int unsigned QUIET_C   = 64;
    localparam int unsigned TIMEOUT_C = 4096;
    localparam int unsigned TS1_MIN_C = 16;
`else
    localparam int unsigned QUIET_C   = QUIET_CYCLES;
    localparam int unsigned TIMEOUT_C = TIMEOUT_CYCLES;
    localparam int unsigned TS1_MIN_C = TS1_TX_MIN;
`endif

    localparam int unsigned LANES  = 4;
    localparam int unsigned SENT_W = 11;
    localparam int unsigned TMO_MAX = (QUIET_C > TIMEOUT_C) ? QUIET_C : TIMEOUT_C;
    localparam int unsigned TMO_W  = $clog2(TMO_MAX + 1);

    localparam logic [7:0] SYM_TS1 = 8'h4A;
    localparam logic [7:0] SYM_TS2 = 8'h45;
    localparam logic [7:0] SYM_PAD = 8'hF7;

    typedef enum logic [2:0] {
        DETECT_QUIET   = 3'd0,
        DETECT_ACTIVE  = 3'd1,
        POLLING_ACTIVE = 3'd2,
        POLLING_CONFIG = 3'd3,
        CONFIG         = 3'd4,
        L0             = 3'd5
    } state_t;

    // Symbol k sits at bits [8k+7:8k]; Sym0 is COM.
    function automatic logic [127:0] ts_build(input logic [7:0] fill,
                                              input logic [7:0] link,
                                              input logic [7:0] lane);
        return {{10{fill}}, 8'h00, 8'h02, 8'h10, lane, link, 8'hBC};
    endfunction

    // Lane bundling
    logic [LANES-1:0] rx_det, idel_break, ack, ts_i_vld;
    logic [127:0]     ts_i [LANES];

    assign rx_det     = {lane3_rx_det, lane2_rx_det, lane1_rx_det, lane0_rx_det};
    assign idel_break = {lane3_idel_break, lane2_idel_break, lane1_idel_break, lane0_idel_break};
    assign ack        = {lane3_rx_det_seq_ack, lane2_rx_det_seq_ack,
                         lane1_rx_det_seq_ack, lane0_rx_det_seq_ack};
    assign ts_i_vld   = {lane3_ts_i_vld, lane2_ts_i_vld, lane1_ts_i_vld, lane0_ts_i_vld};
    assign ts_i[0]    = lane0_ts_i;
    assign ts_i[1]    = lane1_ts_i;
    assign ts_i[2]    = lane2_ts_i;
    assign ts_i[3]    = lane3_ts_i;

    state_t             state, state_d;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [SENT_W-1:0]  sent_cnt;
    logic [LANES-1:0]   act, act_d;
    logic [127:0]       rx_q [LANES];
    logic [LANES-1:0]   rx_vld_q;
    logic [3:0]         rx_cnt [LANES];
    logic [3:0]         rx_cnt_d [LANES];
    logic [LANES-1:0]   match;
    logic [LANES-1:0]   req_q, req_d;
    logic [127:0]       ts_o_q [LANES];
    logic [127:0]       ts_o_d [LANES];
    logic [LANES-1:0]   ts_o_vld_q, ts_o_vld_d;
    logic               linkup_q, linkup_d;
    logic               all8, tmo_hit;

    // Next state and next-cycle outputs (outputs track the state being entered)
    always_comb begin
        state_d    = state;
        act_d      = act;
        req_d      = '0;
        ts_o_vld_d = '0;
        linkup_d   = 1'b0;
        all8       = 1'b1;
        for (int unsigned n = 0; n < LANES; n++) begin
            ts_o_d[n] = '0;
            if (act[n] && (rx_cnt[n] != 4'd8)) all8 = 1'b0;
        end
        tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_C - 1));

        // Exit conditions are checked before timeout so the exit wins a tie
        case (state)
            DETECT_QUIET: begin
                if ((|idel_break) || (tmo_cnt == TMO_W'(QUIET_C - 1)))
                    state_d = DETECT_ACTIVE;
            end
            DETECT_ACTIVE: begin
                if (((rx_det & ~ack) == '0) && (|rx_det)) begin
                    state_d = POLLING_ACTIVE;
                    act_d   = rx_det & ack;
                end else if (tmo_hit) begin
                    state_d = DETECT_QUIET;
                end
            end
            POLLING_ACTIVE: begin
                if ((sent_cnt >= SENT_W'(TS1_MIN_C)) && all8) state_d = POLLING_CONFIG;
                else if (tmo_hit)                             state_d = DETECT_QUIET;
            end
            POLLING_CONFIG: begin
                if ((sent_cnt >= SENT_W'(16)) && all8) state_d = CONFIG;
                else if (tmo_hit)                      state_d = DETECT_QUIET;
            end
            CONFIG: begin
                if ((sent_cnt >= SENT_W'(16)) && all8) state_d = L0;
                else if (tmo_hit)                      state_d = DETECT_QUIET;
            end
            L0:      state_d = L0;
            default: state_d = DETECT_QUIET;
        endcase

        case (state_d)
            DETECT_ACTIVE: req_d = rx_det;
            POLLING_ACTIVE, POLLING_CONFIG, CONFIG: begin
                req_d      = act_d;
                ts_o_vld_d = act_d;
                for (int unsigned n = 0; n < LANES; n++) begin
                    if (act_d[n]) begin
                        if (state_d == POLLING_ACTIVE)
                            ts_o_d[n] = ts_build(SYM_TS1, SYM_PAD, SYM_PAD);
                        else if (state_d == POLLING_CONFIG)
                            ts_o_d[n] = ts_build(SYM_TS2, SYM_PAD, SYM_PAD);
                        else
                            ts_o_d[n] = ts_build(SYM_TS2, 8'h00, 8'(n));
                    end
                end
            end
            L0: begin
                req_d    = act_d;
                linkup_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Per-lane match against the current state's pattern and counter update
    always_comb begin
        for (int unsigned n = 0; n < LANES; n++) begin
            match[n] = 1'b0;
            case (state)
                POLLING_ACTIVE: match[n] = (rx_q[n] == ts_build(SYM_TS1, SYM_PAD, SYM_PAD)) ||
                                           (rx_q[n] == ts_build(SYM_TS2, SYM_PAD, SYM_PAD));
                POLLING_CONFIG: match[n] = (rx_q[n] == ts_build(SYM_TS2, SYM_PAD, SYM_PAD));
                CONFIG:         match[n] = (rx_q[n] == ts_build(SYM_TS2, 8'h00, 8'(n)));
                default:        match[n] = 1'b0;
            endcase
            rx_cnt_d[n] = rx_cnt[n];
            if (state_d != state)
                rx_cnt_d[n] = 4'd0;
            else if (rx_vld_q[n])
                rx_cnt_d[n] = !match[n] ? 4'd0 :
                              (rx_cnt[n] == 4'd8) ? 4'd8 : rx_cnt[n] + 4'd1;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DETECT_QUIET;
            tmo_cnt    <= '0;
            sent_cnt   <= '0;
            act        <= '0;
            rx_vld_q   <= '0;
            req_q      <= '0;
            ts_o_vld_q <= '0;
            linkup_q   <= 1'b0;
            for (int unsigned n = 0; n < LANES; n++) begin
                rx_q[n]   <= '0;
                rx_cnt[n] <= '0;
                ts_o_q[n] <= '0;
            end
        end else begin
            state      <= state_d;
            act        <= act_d;
            rx_vld_q   <= ts_i_vld;
            req_q      <= req_d;
            ts_o_vld_q <= ts_o_vld_d;
            linkup_q   <= linkup_d;
            if (state_d != state)    tmo_cnt <= '0;
            else if (tmo_cnt != '1)  tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (state_d != state)                       sent_cnt <= '0;
            else if ((|ts_o_vld_q) && (sent_cnt != '1)) sent_cnt <= sent_cnt + SENT_W'(1);
            for (int unsigned n = 0; n < LANES; n++) begin
                if (ts_i_vld[n]) rx_q[n] <= ts_i[n];
                rx_cnt[n] <= rx_cnt_d[n];
                ts_o_q[n] <= ts_o_d[n];
            end
        end
    end

    assign {lane3_rx_det_seq_req, lane2_rx_det_seq_req,
            lane1_rx_det_seq_req, lane0_rx_det_seq_req} = req_q;
    assign {lane3_ts_o_vld, lane2_ts_o_vld, lane1_ts_o_vld, lane0_ts_o_vld} = ts_o_vld_q;
    assign lane0_ts_o = ts_o_q[0];
    assign lane1_ts_o = ts_o_q[1];
    assign lane2_ts_o = ts_o_q[2];
    assign lane3_ts_o = ts_o_q[3];
    assign linkup     = linkup_q;

endmodule

// File: tb/tb_ltssm.sv
// tb_ltssm: directed bench for ltssm. Instance dut either trains against a
// cross-wired peer (loop=1) or receives bench-driven ack/TS vectors (loop=0).
module tb_ltssm;
    localparam int unsigned QUIET  = 64;
    localparam int unsigned TMO    = 4096;
    localparam int unsigned TS1MIN = 16;
    localparam logic [7:0]  K_TS1  = 8'h4A;
    localparam logic [7:0]  K_TS2  = 8'h45;
    localparam logic [7:0]  K_PAD  = 8'hF7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         loop;
    logic [3:0]   d_rx_det, p_rx_det, idel;
    logic [3:0]   b_ack, b_vld;
    logic [127:0] b_ts [4];
    logic [3:0]   d_ack, d_vld;
    logic [127:0] d_ts [4];
    logic [3:0]   o_req, o_vld, p_req, p_vld;
    logic [127:0] o_ts [4];
    logic [127:0] p_ts [4];
    logic         o_linkup, p_linkup;

    int checks = 0;
    int errors = 0;

    always_comb begin
        d_ack = loop ? p_req : b_ack;
        d_vld = loop ? p_vld : b_vld;
        for (int n = 0; n < 4; n++) d_ts[n] = loop ? p_ts[n] : b_ts[n];
    end

    ltssm #(.QUIET_CYCLES(QUIET), .TIMEOUT_CYCLES(TMO), .TS1_TX_MIN(TS1MIN)) dut (
        .clk(clk), .rst(rst),
        .lane0_rx_det(d_rx_det[0]), .lane0_idel_break(idel[0]),
        .lane0_rx_det_seq_req(o_req[0]), .lane0_rx_det_seq_ack(d_ack[0]),
        .lane0_ts_i(d_ts[0]), .lane0_ts_i_vld(d_vld[0]),
        .lane0_ts_o(o_ts[0]), .lane0_ts_o_vld(o_vld[0]),
        .lane1_rx_det(d_rx_det[1]), .lane1_idel_break(idel[1]),
        .lane1_rx_det_seq_req(o_req[1]), .lane1_rx_det_seq_ack(d_ack[1]),
        .lane1_ts_i(d_ts[1]), .lane1_ts_i_vld(d_vld[1]),
        .lane1_ts_o(o_ts[1]), .lane1_ts_o_vld(o_vld[1]),
        .lane2_rx_det(d_rx_det[2]), .lane2_idel_break(idel[2]),
        .lane2_rx_det_seq_req(o_req[2]), .lane2_rx_det_seq_ack(d_ack[2]),
        .lane2_ts_i(d_ts[2]), .lane2_ts_i_vld(d_vld[2]),
        .lane2_ts_o(o_ts[2]), .lane2_ts_o_vld(o_vld[2]),
        .lane3_rx_det(d_rx_det[3]), .lane3_idel_break(idel[3]),
        .lane3_rx_det_seq_req(o_req[3]), .lane3_rx_det_seq_ack(d_ack[3]),
        .lane3_ts_i(d_ts[3]), .lane3_ts_i_vld(d_vld[3]),
        .lane3_ts_o(o_ts[3]), .lane3_ts_o_vld(o_vld[3]),
        .linkup(o_linkup)
    );

    ltssm #(.QUIET_CYCLES(QUIET), .TIMEOUT_CYCLES(TMO), .TS1_TX_MIN(TS1MIN)) peer (
        .clk(clk), .rst(rst),
        .lane0_rx_det(p_rx_det[0]), .lane0_idel_break(idel[0]),
        .lane0_rx_det_seq_req(p_req[0]), .lane0_rx_det_seq_ack(o_req[0]),
        .lane0_ts_i(o_ts[0]), .lane0_ts_i_vld(o_vld[0]),
        .lane0_ts_o(p_ts[0]), .lane0_ts_o_vld(p_vld[0]),
        .lane1_rx_det(p_rx_det[1]), .lane1_idel_break(idel[1]),
        .lane1_rx_det_seq_req(p_req[1]), .lane1_rx_det_seq_ack(o_req[1]),
        .lane1_ts_i(o_ts[1]), .lane1_ts_i_vld(o_vld[1]),
        .lane1_ts_o(p_ts[1]), .lane1_ts_o_vld(p_vld[1]),
        .lane2_rx_det(p_rx_det[2]), .lane2_idel_break(idel[2]),
        .lane2_rx_det_seq_req(p_req[2]), .lane2_rx_det_seq_ack(o_req[2]),
        .lane2_ts_i(o_ts[2]), .lane2_ts_i_vld(o_vld[2]),
        .lane2_ts_o(p_ts[2]), .lane2_ts_o_vld(p_vld[2]),
        .lane3_rx_det(p_rx_det[3]), .lane3_idel_break(idel[3]),
        .lane3_rx_det_seq_req(p_req[3]), .lane3_rx_det_seq_ack(o_req[3]),
        .lane3_ts_i(o_ts[3]), .lane3_ts_i_vld(o_vld[3]),
        .lane3_ts_o(p_ts[3]), .lane3_ts_o_vld(p_vld[3]),
        .linkup(p_linkup)
    );

    function automatic logic [127:0] mk_ts(input logic [7:0] fill, input logic [7:0] link,
                                           input logic [7:0] lane);
        return {{10{fill}}, 8'h00, 8'h02, 8'h10, lane, link, 8'hBC};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset both instances, leave them in Detect.Quiet with idle inputs
    task automatic do_reset(input logic lp, input logic [3:0] dmask, input logic [3:0] pmask);
        rst = 1'b1; loop = lp; d_rx_det = dmask; p_rx_det = pmask; idel = 4'h0;
        tickn(2);
        rst = 1'b0;
    endtask

    // Back-to-back training with cycle-exact checkpoints; cycle k counts
    // edges after the one that samples idel_break (DETECT_ACTIVE entry).
    task automatic train(input logic [3:0] mask);
        logic bad;
        bad = 1'b0;
        do_reset(1'b1, mask, mask);
        tickn(10);
        check("quiet_before_idel", 128'(o_req), 128'(0));
        idel = 4'hF;
        tick();
        idel = 4'h0;
        check("da_req", 128'(o_req), 128'(mask));
        for (int k = 1; k <= 52; k++) begin
            tick();
            if (((o_vld | p_vld) & ~mask) != 4'h0) bad = 1'b1;
            if (k == 1 || k == 17) begin
                check("pa_vld", 128'(o_vld), 128'(mask));
                check("pa_ts1", o_ts[0], mk_ts(K_TS1, K_PAD, K_PAD));
            end
            if (k == 18 || k == 34)
                check("pc_ts2", o_ts[0], mk_ts(K_TS2, K_PAD, K_PAD));
            if (k == 35)
                for (int n = 0; n < 4; n++)
                    check($sformatf("cfg_ts_lane%0d", n), o_ts[n],
                          mask[n] ? mk_ts(K_TS2, 8'h00, 8'(n)) : 128'(0));
            if (k == 51) check("linkup_not_early", 128'({o_linkup, p_linkup}), 128'(0));
        end
        check("linkup_both", 128'({o_linkup, p_linkup}), 128'(2'b11));
        check("l0_vld_zero", 128'(o_vld), 128'(0));
        check("l0_ts_zero", o_ts[0], 128'(0));
        check("l0_req_held", 128'(o_req), 128'(mask));
        check("inactive_lanes_silent", 128'(bad), 128'(0));
    endtask

    initial begin
        logic bad;
        logic [127:0] corrupt;
        loop = 1'b0; d_rx_det = 4'hF; p_rx_det = 4'hF; idel = 4'hF;
        b_ack = 4'h0; b_vld = 4'h0;
        for (int n = 0; n < 4; n++) b_ts[n] = '0;

        // Reset held with idel_break asserted: everything stays at zero
        rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if ({o_req, o_vld, o_linkup, p_req, p_vld, p_linkup} != '0) bad = 1'b1;
            for (int n = 0; n < 4; n++) if (o_ts[n] != '0) bad = 1'b1;
        end
        check("reset_outputs_zero", 128'(bad), 128'(0));
        rst = 1'b0;
        tick();
        check("first_edge_after_rst", 128'(o_req), 128'(4'hF));
        idel = 4'h0;

        // No partner ack: Detect.Active lasts exactly TMO cycles, then Quiet dwell
        tickn(TMO - 1);
        check("da_hold_pre_timeout", 128'(o_req), 128'(4'hF));
        tick();
        check("da_timeout_exit", 128'(o_req), 128'(0));
        check("noack_no_linkup", 128'(o_linkup), 128'(0));
        tickn(QUIET - 1);
        check("quiet_dwell_hold", 128'(o_req), 128'(0));
        tick();
        check("quiet_dwell_exit", 128'(o_req), 128'(4'hF));

        // Full and partial lane back-to-back training
        train(4'hF);
        train(4'h3);

        // Reset in CONFIG, then retrain
        do_reset(1'b1, 4'hF, 4'hF);
        idel = 4'hF;
        tick();
        idel = 4'h0;
        tickn(39);
        check("in_config", o_ts[1], mk_ts(K_TS2, 8'h00, 8'h01));
        rst = 1'b1;
        tick();
        check("midrst_req", 128'(o_req), 128'(0));
        check("midrst_vld", 128'(o_vld), 128'(0));
        check("midrst_ts", o_ts[1], 128'(0));
        rst = 1'b0;
        idel = 4'hF;
        tick();
        idel = 4'h0;
        tickn(51);
        check("retrain_not_early", 128'(o_linkup), 128'(0));
        tick();
        check("retrain_linkup", 128'({o_linkup, p_linkup}), 128'(2'b11));

        // Corrupt TS on lane 1 during Polling.Active (bench-driven partner)
        b_ack = 4'hF;
        b_vld = 4'b1101;
        for (int n = 0; n < 4; n++) b_ts[n] = mk_ts(K_TS1, K_PAD, K_PAD);
        do_reset(1'b0, 4'hF, 4'hF);
        idel = 4'hF;
        tick();
        idel = 4'h0;
        tickn(24);
        check("pa_wait_lane1", o_ts[0], mk_ts(K_TS1, K_PAD, K_PAD));
        check("pa_lane2_pad", o_ts[2], mk_ts(K_TS1, K_PAD, K_PAD));
        b_vld[1] = 1'b1;
        tickn(7);
        corrupt = mk_ts(K_TS1, K_PAD, K_PAD);
        corrupt[7:0] = 8'h00;
        b_ts[1] = corrupt;
        tick();
        b_ts[1] = mk_ts(K_TS1, K_PAD, K_PAD);
        tickn(2);
        check("corrupt_resets_count", o_ts[0], mk_ts(K_TS1, K_PAD, K_PAD));
        tickn(7);
        check("corrupt_still_pa", o_ts[0], mk_ts(K_TS1, K_PAD, K_PAD));
        tick();
        check("corrupt_late_exit", o_ts[0], mk_ts(K_TS2, K_PAD, K_PAD));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ltssm.md
# ltssm

Simplified 4-lane PCIe Link Training and Status State Machine for simulation-level link bring-up. Two identical instances are cross-connected back to back, one acting as downstream port and one as upstream port. Each instance performs receiver detection via a req/ack sequence, exchanges 128-bit TS1/TS2 ordered sets, and asserts `linkup` on reaching L0. Electrical-idle-break inputs come from an external fixed-delay stage (`delay_shim`) outside this block.

## Interface
- `QUIET_CYCLES`, 12000: Detect.Quiet dwell before self-exit.
- `TIMEOUT_CYCLES`, 24000: per-state timeout for Detect.Active, Polling and Config.
- `TS1_TX_MIN`, 1024: TS1 count that must be sent in Polling.Active.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `laneN_rx_det` input 1 (N=0..3): lane N has a receiver termination present.
- `laneN_idel_break` input 1: electrical idle exited on lane N.
- `laneN_rx_det_seq_req` output 1: local detect request, wired to the partner's ack.
- `laneN_rx_det_seq_ack` input 1: partner's detect request.
- `laneN_ts_i` input 128: received ordered set.
- `laneN_ts_i_vld` input 1: `laneN_ts_i` valid this cycle.
- `laneN_ts_o` output 128: transmitted ordered set.
- `laneN_ts_o_vld` output 1: `laneN_ts_o` valid this cycle.
- `linkup` output 1: link is in L0.

## Operation
- **TS format:** symbol k occupies bits [8k+7:8k].
  - Sym0 = COM 0xBC.
  - Sym1 = link number (PAD 0xF7 or 0x00).
  - Sym2 = lane number (PAD 0xF7 or N).
  - Sym3 = N_FTS 0x10; Sym4 = rate 0x02; Sym5 = 0x00.
  - Sym6–15 = 0x4A for TS1, 0x45 for TS2.
- **Active lanes:** mask `act` = `rx_det` & `rx_det_seq_ack`, latched on exit from Detect.Active. Only active lanes transmit and are checked.
- **Per-lane receive counter:** 4-bit.
  - +1 on a valid TS matching the current state's expected pattern; saturates at 8.
  - Cleared to 0 on a valid non-matching TS.
  - Holds when `ts_i_vld`=0.
  - Cleared on every state change.
- **Sent counter:** 11-bit, counts `ts_o_vld` cycles; cleared on every state change.
- **State encoding:** DETECT_QUIET=0, DETECT_ACTIVE=1, POLLING_ACTIVE=2, POLLING_CONFIG=3, CONFIG=4, L0=5.
- **State transitions:**
  - DETECT_QUIET: goes to DETECT_ACTIVE when any `idel_break`=1 or the dwell timer reaches `QUIET_CYCLES`.
  - DETECT_ACTIVE:
    - drives `req[N]` = `rx_det[N]`;
    - goes to POLLING_ACTIVE when every lane with `rx_det`=1 also has `ack`=1 and at least one such lane exists;
    - goes to DETECT_QUIET on timeout.
  - POLLING_ACTIVE:
    - sends TS1 with link = PAD, lane = PAD, `vld`=1 every cycle;
    - goes to POLLING_CONFIG when sent ≥ `TS1_TX_MIN` and all active counters = 8 (TS1 or TS2, both with PAD link/lane, count as matching);
    - goes to DETECT_QUIET on timeout.
  - POLLING_CONFIG:
    - sends TS2 with PAD link/lane;
    - goes to CONFIG when all active counters = 8 on TS2 and sent ≥ 16;
    - goes to DETECT_QUIET on timeout.
  - CONFIG:
    - sends TS2 with link = 0x00, lane = N;
    - a match requires TS2 with link 0x00 and lane N;
    - goes to L0 when all active counters = 8 and sent ≥ 16;
    - goes to DETECT_QUIET on timeout.
  - L0: `linkup`=1, `ts_o_vld`=0, `ts_o`=0. Terminal until `rst`.
- `req` stays asserted in every state except DETECT_QUIET, so a partner entering later still sees it.
- Timeout counter: one shared counter, cleared on every state change.

## Timing
- All outputs registered.
- Reset values: state DETECT_QUIET; `req`=0, `ts_o`=0, `ts_o_vld`=0 on all lanes; `linkup`=0; all counters 0.
- `rst` mid-operation returns the block to reset values at the next edge.
- State change is registered: a condition true in cycle t changes the state at edge t+1. Outputs for the new state appear in that same cycle.
- Received TS are sampled on the edge where `vld`=1, and counter and exit evaluation use that registered value. Reaching 8 therefore takes at least 8 cycles after the first matching TS.
- Simultaneous exit condition and timeout: the exit wins.
- Inactive lanes: `ts_o_vld`=0 and `req`=0.

## Configuration
- `LTSSM_FAST_SIM_EN` defined: overrides the parameters to `QUIET_CYCLES`=64, `TIMEOUT_CYCLES`=4096, `TS1_TX_MIN`=16.
- Undefined: the parameter values are used as given.
- Transition rules are identical in both cases.

## Test plan
- **Back-to-back link-up:** two instances cross-wired; `rx_det`=1 on all lanes; `idel_break` rises 500 cycles after reset; `LTSSM_FAST_SIM_EN` defined.
  - Required: both instances reach L0, `linkup`=1, within 700 cycles of `idel_break`.
- **Reset values:** hold `rst`=1 for 100 cycles.
  - Required: all outputs 0 and state 0 throughout; first transition no earlier than the edge after `rst` falls.
- **No partner ack:** `ack` tied 0.
  - Required: DETECT_ACTIVE→DETECT_QUIET after exactly `TIMEOUT_CYCLES`; `linkup` stays 0.
- **Partial lane set:** lanes 2–3 `rx_det`=0.
  - Required: link-up on lanes 0–1 only; lanes 2–3 `ts_o_vld`=0 throughout; CONFIG TS2 carries lane numbers 0x00 and 0x01.
- **Corrupt TS:** one TS with Sym0=0x00 after 7 good TS1 on lane 1.
  - Required: lane 1 counter resets to 0; POLLING_ACTIVE exit delayed by at least 8 further valid cycles.
- **Mid-training reset:** assert `rst` in CONFIG.
  - Required: DETECT_QUIET and `req`=0 on the next edge; full re-train to L0 after release.
